// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 inverse key schedule.
// Holds the round count, first/last round constants, the sequencer state
// encoding, the GF(2^8) xtime helper and the forward S-box table.
package aes_pkg;

    localparam int         AES_NR     = 10;
    localparam logic [7:0] RCON_FIRST = 8'h01;
    localparam logic [7:0] RCON_LAST  = 8'h36;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2
    } state_t;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES forward S-box, purely combinational table lookup.
// Ports:
//   in_i  [7:0]  byte to substitute
//   out_o [7:0]  substituted byte
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule: round-key source for the decryption datapath.
// Takes a cipher key, runs the forward schedule up to round 10 (one step per
// cycle), then walks the schedule backwards, emitting round keys 10..0.
// Four S-box instances are shared between the forward and reverse steps.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   key_valid/key_ready cipher key handshake; key_ready is high only when idle
//   key_in   [127:0]    cipher key, byte0 in [127:120]
//   rk_valid/rk_ready   round key handshake
//   rk_out   [127:0]    registered round key
//   rk_round [3:0]      round index of rk_out
//   rk_last             rk_valid with round 0
//
// Optional build macro AES_INV_KEY_CACHE_EN: remembers the last fully expanded
// key and its round-10 key; re-submitting that key skips the forward pass.
module aes_inv_key_sched
    import aes_pkg::*;
#(
    parameter int KEY_W = 128,
    parameter int NR    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [KEY_W-1:0] key_in,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk_out,
    output logic [3:0]       rk_round,
    output logic             rk_last
);

    if (KEY_W != 128 || NR != AES_NR) begin : g_bad_param
        $error("aes_inv_key_sched supports only KEY_W=128, NR=10");
    end

    localparam logic [3:0] NR_L = 4'(NR);

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // sw = SubWord(RotWord(w3)) of the incoming key.
    function automatic logic [127:0] fwd_step(input logic [127:0] k,
                                              input logic [7:0]   rc,
                                              input logic [31:0]  sw);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sw ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // sw = SubWord(RotWord(w3')) where w3' is the recovered previous w3.
    function automatic logic [127:0] inv_step(input logic [127:0] k,
                                              input logic [7:0]   rc,
                                              input logic [31:0]  sw);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sw ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    state_t         state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [7:0]     rcon_q, rcon_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [127:0]   rk_out_q, rk_out_d;
    logic [3:0]     rk_round_q, rk_round_d;
    logic           rk_valid_q, rk_valid_d;

`ifdef AES_INV_KEY_CACHE_EN
    logic [127:0]   cached_key_q, cached_key_d;
    logic [127:0]   cached_last_q, cached_last_d;
    logic           cache_vld_q, cache_vld_d;
    logic [127:0]   pend_key_q, pend_key_d;   // key being expanded, cached at FWD end
    logic           hit_q, hit_d;             // FWD pass is a cache replay
`endif

    // Shared S-box path: forward step consumes the current w3, reverse step
    // consumes the recovered w3' of the previous round.
    logic [31:0]    inv_w3;
    logic [31:0]    sb_word;
    logic [3:0][7:0] sb_out;
    logic [127:0]   fwd_res, inv_res;
    logic           fwd_done;

    assign inv_w3  = rk_out_q[31:0] ^ rk_out_q[63:32];
    assign sb_word = (state_q == REV) ? rot_word(inv_w3) : rot_word(key_q[31:0]);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (sb_word[8*i +: 8]),
            .out_o (sb_out[i])
        );
    end

    assign fwd_res = fwd_step(key_q, rcon_q, sb_out);
    assign inv_res = inv_step(rk_out_q, rcon_q, sb_out);

`ifdef AES_INV_KEY_CACHE_EN
    assign fwd_done = (cnt_q == NR_L) || hit_q;
`else
    assign fwd_done = (cnt_q == NR_L);
`endif

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        rcon_d     = rcon_q;
        cnt_d      = cnt_q;
        rk_out_d   = rk_out_q;
        rk_round_d = rk_round_q;
        rk_valid_d = rk_valid_q;
`ifdef AES_INV_KEY_CACHE_EN
        cached_key_d  = cached_key_q;
        cached_last_d = cached_last_q;
        cache_vld_d   = cache_vld_q;
        pend_key_d    = pend_key_q;
        hit_d         = hit_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (key_valid) begin
                    key_d   = key_in;
                    rcon_d  = RCON_FIRST;
                    cnt_d   = 4'd1;
                    state_d = FWD;
`ifdef AES_INV_KEY_CACHE_EN
                    hit_d      = cache_vld_q && (key_in == cached_key_q);
                    pend_key_d = key_in;
`endif
                end
            end
            FWD: begin
                key_d  = fwd_res;
                rcon_d = xtime(rcon_q);
                cnt_d  = cnt_q + 4'd1;
                if (fwd_done) begin
                    rk_out_d   = fwd_res;
                    rk_round_d = NR_L;
                    rk_valid_d = 1'b1;
                    rcon_d     = RCON_LAST;
                    state_d    = REV;
`ifdef AES_INV_KEY_CACHE_EN
                    hit_d = 1'b0;
                    if (hit_q) begin
                        rk_out_d = cached_last_q;
                    end else begin
                        cached_key_d  = pend_key_q;
                        cached_last_d = fwd_res;
                        cache_vld_d   = 1'b1;
                    end
`endif
                end
            end
            REV: begin
                if (rk_valid_q && rk_ready) begin
                    if (rk_round_q != 4'd0) begin
                        rk_out_d   = inv_res;
                        rk_round_d = rk_round_q - 4'd1;
                        // Inverse of xtime over the rcon sequence; 1b is the
                        // only value produced by the polynomial reduction.
                        rcon_d     = (rcon_q == 8'h1b) ? 8'h80 : (rcon_q >> 1);
                    end else begin
                        rk_valid_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            key_q      <= '0;
            rcon_q     <= RCON_FIRST;
            cnt_q      <= '0;
            rk_out_q   <= '0;
            rk_round_q <= '0;
            rk_valid_q <= 1'b0;
`ifdef AES_INV_KEY_CACHE_EN
            cached_key_q  <= '0;
            cached_last_q <= '0;
            cache_vld_q   <= 1'b0;
            pend_key_q    <= '0;
            hit_q         <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            rcon_q     <= rcon_d;
            cnt_q      <= cnt_d;
            rk_out_q   <= rk_out_d;
            rk_round_q <= rk_round_d;
            rk_valid_q <= rk_valid_d;
`ifdef AES_INV_KEY_CACHE_EN
            cached_key_q  <= cached_key_d;
            cached_last_q <= cached_last_d;
            cache_vld_q   <= cache_vld_d;
            pend_key_q    <= pend_key_d;
            hit_q         <= hit_d;
`endif
        end
    end

    assign key_ready = (state_q == IDLE);
    assign rk_valid  = rk_valid_q;
    assign rk_out    = rk_out_q;
    assign rk_round  = rk_round_q;
    assign rk_last   = rk_valid_q && (rk_round_q == 4'd0);

endmodule
